bus_grant_ctrl: RTL and testbench

- Downstream consumer of the bus request queue.
- Pops one queued sender at a time by driving `pull`, then grants the shared bus to that sender (four units plus DMA) and holds the grant until the owner signals `done`.
- Inserts a one-cycle dead turnaround before the next owner is granted.
- Optionally forces release of a sender that holds the bus too long.

---
 rtl/bus_grant_ctrl.sv | 110 +++++++++++
 tb/tb_bus_grant_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_grant_ctrl.sv
// Bus grant controller: pops one queued sender, grants the bus until done, then one dead turnaround cycle.
// Optional forced release after MAX_HOLD grant cycles when BUS_HOLD_TIMEOUT_EN is defined.
module bus_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned CNT_W    = 7
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       valid,
  input  logic [3:0] send_id,
  input  logic [4:0] done,
  output logic       pull,
  output logic [4:0] grant,
  output logic       bus_busy,
  output logic [3:0] owner_id,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t     state_q;
  logic [4:0] grant_q;
  logic [3:0] owner_q;
  logic       owner_done;

  function automatic logic [4:0] decode_grant(input logic [3:0] id);
    if (id[3:2] == 2'b11) return 5'b10000;
    return 5'b00001 << id[1:0];
  endfunction

  assign owner_done = |(done & grant_q);

`ifdef BUS_HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             hold_expired;

  assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
`ifdef BUS_HOLD_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef BUS_HOLD_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (valid) begin
            owner_q <= send_id;
            grant_q <= decode_grant(send_id);
`ifdef BUS_HOLD_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            state_q <= GRANT;
          end
        end
        GRANT: begin
`ifdef BUS_HOLD_TIMEOUT_EN
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
`endif
          // done from the owner takes priority over a coincident hold expiry
          if (owner_done) begin
            grant_q <= '0;
            state_q <= TURN;
          end
`ifdef BUS_HOLD_TIMEOUT_EN
          else if (hold_expired) begin
            grant_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= TURN;
          end
`endif
        end
        TURN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Gated by clr so the queue cannot pop while reset is held
  assign pull     = clr & (state_q == IDLE);
  assign grant    = grant_q;
  assign bus_busy = (state_q == GRANT);
  assign owner_id = owner_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!clr) $onehot0(grant_q));
  a_param_legal  : assert property (@(posedge clk)
    (MAX_HOLD >= 2) && (MAX_HOLD <= 127) && ((MAX_HOLD >> CNT_W) == 0));

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Scoreboard bench for bus_grant_ctrl: driver pushes expected grant runs, a monitor pops and compares them.
module tb_bus_grant_ctrl;

  localparam int unsigned TB_MAX_HOLD = 6;
`ifdef BUS_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] send_id = '0;
  logic [4:0] done = '0;
  logic       pull;
  logic [4:0] grant;
  logic       bus_busy;
  logic [3:0] owner_id;
  logic       timeout;

  bus_grant_ctrl #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(7)) dut (
    .clk(clk), .clr(clr), .valid(valid), .send_id(send_id), .done(done),
    .pull(pull), .grant(grant), .bus_busy(bus_busy), .owner_id(owner_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  g;
    logic [3:0]  id;
    int unsigned len;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: DMA for codes 12..15, otherwise unit (id mod 4)
  function automatic logic [4:0] exp_grant(input logic [3:0] id);
    int unsigned idx;
    idx = (id >= 12) ? 4 : (id % 4);
    return 5'(1 << idx);
  endfunction

  // Driver: waits for pull, issues one entry, owner releases on grant cycle len
  task automatic run_txn(input logic [3:0] id, input int unsigned len, input int noise);
    logic [4:0]  gbit;
    logic [4:0]  nz;
    int unsigned waits;
    exp_t        e;
    gbit  = exp_grant(id);
    waits = 0;
    while (!pull && waits < 50) begin
      valid = 1'b0;
      done  = 5'($urandom);
      @(posedge clk); #1;
      waits++;
    end
    if (!pull) begin
      chk("pull_wait", 32'(pull), 32'd1);
      return;
    end
    valid   = 1'b1;
    send_id = id;
    done    = 5'($urandom);
    e.g   = gbit;
    e.id  = id;
    e.to  = TO_EN && (len > TB_MAX_HOLD);
    e.len = e.to ? TB_MAX_HOLD : len;
    sb.push_back(e);
    @(posedge clk); #1;
    for (int unsigned k = 1; k <= len; k++) begin
      if (grant == '0) break;
      nz      = (noise < 0) ? 5'($urandom) : 5'(noise);
      nz      = nz & ~gbit;
      done    = (k == len) ? (nz | gbit) : nz;
      valid   = 1'($urandom);
      send_id = 4'($urandom);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    done  = '0;
  endtask

  // Monitor: tracks each grant run and compares it against the scoreboard head
  int unsigned run_len = 0;
  logic [4:0]  run_g   = '0;
  logic        run_bad = 1'b0;
  logic        pend    = 1'b0;
  exp_t        me;

  always @(negedge clk) begin
    if (!clr) begin
      run_len = 0;
      pend    = 1'b0;
    end else if (grant != '0) begin
      if (run_len == 0) begin
        if (pend) begin
          chk("turnaround_gap", 32'(grant), 32'd0);
          pend = 1'b0;
        end
        run_g   = grant;
        run_bad = 1'b0;
      end
      if (grant !== run_g || !bus_busy || pull || $countones(grant) != 1) run_bad = 1'b1;
      run_len++;
    end else if (run_len > 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", 32'(run_g), 32'd0);
      end else begin
        me = sb.pop_front();
        chk("grant_bits", 32'(run_g), 32'(me.g));
        chk("owner_id", 32'(owner_id), 32'(me.id));
        chk("grant_len", run_len, me.len);
        chk("turn_timeout", 32'(timeout), 32'(me.to));
      end
      chk("run_stable", 32'(run_bad), 32'd0);
      chk("turn_busy", 32'(bus_busy), 32'd0);
      chk("turn_pull", 32'(pull), 32'd0);
      run_len = 0;
      pend    = 1'b1;
    end else if (pend) begin
      chk("idle_pull", 32'(pull), 32'd1);
      chk("idle_timeout", 32'(timeout), 32'd0);
      pend = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_pull", 32'(pull), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(bus_busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b1;
    #1;
    chk("post_rst_pull", 32'(pull), 32'd1);
    chk("post_rst_grant", 32'(grant), 32'd0);
    chk("post_rst_owner", 32'(owner_id), 32'd0);
    chk("post_rst_busy", 32'(bus_busy), 32'd0);

    run_txn(4'h2, 4, 5'b00001);
    run_txn(4'hC, 1, -1);
    run_txn(4'h1, 3, -1);
    run_txn(4'h3, 2, -1);
    run_txn(4'hF, 20, -1);
    run_txn(4'h0, TB_MAX_HOLD, -1);
    run_txn(4'h5, TB_MAX_HOLD + 1, -1);

    // Asynchronous reset between edges during a grant
    while (!pull) begin @(posedge clk); #1; end
    valid   = 1'b1;
    send_id = 4'h1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("rst_pre_grant", 32'(grant), 32'h02);
    #3;
    clr = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_pull", 32'(pull), 32'd0);
    chk("async_busy", 32'(bus_busy), 32'd0);
    done = 5'b00010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    #1;
    chk("rel_pull", 32'(pull), 32'd1);
    chk("rel_owner", 32'(owner_id), 32'd0);
    @(posedge clk); #1;
    chk("rel_no_grant", 32'(grant), 32'd0);
    chk("rel_still_idle", 32'(pull), 32'd1);
    done = '0;

    for (int i = 0; i < 30; i++) begin
      run_txn(4'($urandom_range(0, 15)), $urandom_range(1, 9), -1);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
